cpu0_mem: RTL and testbench

Word-addressed memory responder on the far end of the `cpu0` memory interface. It answers CPU reads and writes on `address_bus`, `data_bus` and `wr`, and owns the tri-state drive of `data_bus` during reads. It also provides a host loader port that preloads program words while the CPU is held off the bus. After reset it clears its own contents with a sequential sweep before serving any traffic.

---
 rtl/cpu0_pkg.sv | 15 +
 rtl/cpu0_mem_array.sv | 26 ++
 rtl/cpu0_mem.sv | 138 +++++++++++++
 tb/tb_cpu0_mem.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu0_pkg.sv
// Shared types and constants for the cpu0 memory interface.
package cpu0_pkg;

    typedef enum logic [1:0] {
        MEM_CLEAR = 2'd0,
        MEM_IDLE  = 2'd1,
        MEM_LOAD  = 2'd2
    } mem_state_t;

    localparam int unsigned DATA_W_C = 16;

    localparam logic WR_READ  = 1'b1;
    localparam logic WR_WRITE = 1'b0;

endpackage

// File: rtl/cpu0_mem_array.sv
// Word storage: one synchronous write port, one asynchronous read port, no reset.
module mem_array #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cpu0_mem.sv
// Memory responder for the cpu0 bus: CPU read/write service, host burst loader,
// and a post-reset clear sweep, all sharing one write port of mem_array.
module cpu0_mem
    import cpu0_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = DATA_W_C
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic [15:0]       address_bus,
    inout  wire  [DATA_W-1:0] data_bus,
    input  logic              load_mode,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              busy,
    output logic [ADDR_W:0]   load_count
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] PTR_LAST  = '1;
    localparam logic [CNT_W-1:0]  COUNT_MAX = CNT_W'(1) << ADDR_W;

    localparam logic [1:0] ST_CLEAR = MEM_CLEAR;
    localparam logic [1:0] ST_IDLE  = MEM_IDLE;
    localparam logic [1:0] ST_LOAD  = MEM_LOAD;

    logic [1:0]        state;
    logic [1:0]        state_nxt_c;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_nxt_c;
    logic [CNT_W-1:0]  count_nxt_c;

    logic              hit_c;
    logic              drive_en_c;
    logic [ADDR_W-1:0] cpu_addr_c;
    logic [DATA_W-1:0] rd_word_c;
    logic [DATA_W-1:0] mem_rdata;

    logic              we_c;
    logic [ADDR_W-1:0] waddr_c;
    logic [DATA_W-1:0] wdata_c;

    // Address decode and combinational read path onto the shared bus
    assign cpu_addr_c = address_bus[ADDR_W-1:0];
    assign hit_c      = (address_bus >> ADDR_W) == 16'd0;
    assign drive_en_c = (wr == WR_READ) && (state == ST_IDLE) && !load_mode;
    assign rd_word_c  = hit_c ? mem_rdata : '0;
    assign data_bus   = drive_en_c ? rd_word_c : 'z;

    mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem_array (
        .clk   (clk),
        .we    (we_c),
        .waddr (waddr_c),
        .wdata (wdata_c),
        .raddr (cpu_addr_c),
        .rdata (mem_rdata)
    );

    // Next-state logic and write-port mux (sweep, loader, CPU)
    always_comb begin
        state_nxt_c = state;
        ptr_nxt_c   = ptr;
        count_nxt_c = load_count;
        we_c        = 1'b0;
        waddr_c     = ptr;
        wdata_c     = '0;

        case (state)
            ST_CLEAR: begin
                we_c      = 1'b1;
                ptr_nxt_c = ptr + ADDR_W'(1);
                if (ptr == PTR_LAST) begin
                    state_nxt_c = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (load_mode) begin
                    if (load_start) begin
                        state_nxt_c = ST_LOAD;
                        ptr_nxt_c   = load_base;
                        count_nxt_c = '0;
                    end
                end else if ((wr == WR_WRITE) && hit_c) begin
                    we_c    = 1'b1;
                    waddr_c = cpu_addr_c;
                    wdata_c = data_bus;
                end
            end
            ST_LOAD: begin
                // Dropping load_mode aborts without writing the pending word
                if (!load_mode) begin
                    state_nxt_c = ST_IDLE;
                end else if (load_valid) begin
                    we_c      = 1'b1;
                    wdata_c   = load_data;
                    ptr_nxt_c = ptr + ADDR_W'(1);
                    if (load_count != COUNT_MAX) begin
                        count_nxt_c = load_count + CNT_W'(1);
                    end
                    if (load_last) begin
                        state_nxt_c = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nxt_c = ST_CLEAR;
                ptr_nxt_c   = '0;
            end
        endcase
    end

    // State and registered status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_CLEAR;
            ptr        <= '0;
            load_count <= '0;
            busy       <= 1'b1;
            load_ready <= 1'b0;
        end else begin
            state      <= state_nxt_c;
            ptr        <= ptr_nxt_c;
            load_count <= count_nxt_c;
            busy       <= (state_nxt_c != ST_IDLE);
            load_ready <= (state_nxt_c == ST_LOAD);
        end
    end

endmodule

// File: tb/tb_cpu0_mem.sv
// Directed self-checking bench for cpu0_mem; an undriven bus reads as all ones.
module tb_cpu0_mem;
    import cpu0_pkg::*;

    localparam int unsigned ADDR_W = 8;
    localparam logic [15:0] BUS_FLOAT = 16'hFFFF;

    logic              clk;
    logic              reset;
    logic              wr;
    logic [15:0]       address_bus;
    tri1  [15:0]       data_bus;
    logic              load_mode;
    logic              load_start;
    logic [ADDR_W-1:0] load_base;
    logic              load_valid;
    logic [15:0]       load_data;
    logic              load_last;
    logic              load_ready;
    logic              busy;
    logic [ADDR_W:0]   load_count;

    logic              tb_oe;
    logic [15:0]       tb_drive;

    int n_checks;
    int n_fail;

    assign data_bus = tb_oe ? tb_drive : 'z;

    cpu0_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr          (wr),
        .address_bus (address_bus),
        .data_bus    (data_bus),
        .load_mode   (load_mode),
        .load_start  (load_start),
        .load_base   (load_base),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .busy        (busy),
        .load_count  (load_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
        string       name;
    } cpu_vec_t;

    cpu_vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cpu_read(input logic [15:0] addr, input logic [15:0] exp, input string name);
        wr          = WR_READ;
        address_bus = addr;
        #1;
        check(name, 32'(data_bus), 32'(exp));
        cycle();
    endtask

    task automatic cpu_write(input logic [15:0] addr, input logic [15:0] data);
        wr          = WR_WRITE;
        address_bus = addr;
        tb_drive    = data;
        tb_oe       = 1'b1;
        cycle();
        tb_oe       = 1'b0;
        wr          = WR_READ;
    endtask

    task automatic wait_clear(input string name);
        int n;
        n = 0;
        while ((busy === 1'b1) && (n < 1000)) begin
            cycle();
            n++;
        end
        check(name, 32'(n), 32'd256);
    endtask

    task automatic start_burst(input logic [ADDR_W-1:0] base);
        load_mode  = 1'b1;
        load_start = 1'b1;
        load_base  = base;
        cycle();
        load_start = 1'b0;
    endtask

    task automatic push_word(input logic [15:0] data, input logic last);
        load_valid = 1'b1;
        load_data  = data;
        load_last  = last;
        cycle();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        reset       = 1'b0;
        wr          = WR_READ;
        address_bus = 16'h0037;
        load_mode   = 1'b0;
        load_start  = 1'b0;
        load_base   = '0;
        load_valid  = 1'b0;
        load_data   = '0;
        load_last   = 1'b0;
        tb_oe       = 1'b0;
        tb_drive    = '0;

        vecs[0]  = '{WR_READ,  16'h0037, 16'h0000, "rd_cleared_0037"};
        vecs[1]  = '{WR_WRITE, 16'h0012, 16'hBEEF, ""};
        vecs[2]  = '{WR_READ,  16'h0012, 16'hBEEF, "rd_after_wr_0012"};
        vecs[3]  = '{WR_READ,  16'h0112, 16'h0000, "rd_miss_0112"};
        vecs[4]  = '{WR_WRITE, 16'h0112, 16'h1234, ""};
        vecs[5]  = '{WR_READ,  16'h0012, 16'hBEEF, "miss_wr_no_alias"};
        vecs[6]  = '{WR_WRITE, 16'h00FF, 16'hA5A5, ""};
        vecs[7]  = '{WR_READ,  16'h00FF, 16'hA5A5, "rd_top_00ff"};
        vecs[8]  = '{WR_READ,  16'hFF00, 16'h0000, "rd_miss_ff00"};
        vecs[9]  = '{WR_WRITE, 16'h0000, 16'h5A5A, ""};
        vecs[10] = '{WR_READ,  16'h0000, 16'h5A5A, "rd_bottom_0000"};
        vecs[11] = '{WR_READ,  16'h8012, 16'h0000, "rd_miss_8012"};

        // Reset state and clear sweep duration
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_load_ready", 32'(load_ready), 32'd0);
        check("rst_load_count", 32'(load_count), 32'd0);
        check("rst_bus_float", 32'(data_bus), 32'(BUS_FLOAT));
        reset = 1'b1;
        #1;
        check("clear_bus_float", 32'(data_bus), 32'(BUS_FLOAT));
        wait_clear("clear_cycles");

        // CPU vector table
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wr == WR_WRITE) begin
                cpu_write(vecs[i].addr, vecs[i].data);
            end else begin
                cpu_read(vecs[i].addr, vecs[i].data, vecs[i].name);
            end
        end

        // Wrapping load burst
        start_burst(8'hFE);
        check("burst_ready", 32'(load_ready), 32'd1);
        check("burst_busy", 32'(busy), 32'd1);
        #1;
        check("burst_bus_float", 32'(data_bus), 32'(BUS_FLOAT));
        push_word(16'h1111, 1'b0);
        push_word(16'h2222, 1'b0);
        push_word(16'h3333, 1'b1);
        check("burst_ready_drop", 32'(load_ready), 32'd0);
        check("burst_count", 32'(load_count), 32'd3);
        check("burst_not_busy", 32'(busy), 32'd0);
        load_mode = 1'b0;
        cpu_read(16'h00FE, 16'h1111, "burst_rd_fe");
        cpu_read(16'h00FF, 16'h2222, "burst_rd_ff");
        cpu_read(16'h0000, 16'h3333, "burst_rd_00");

        // Abort by dropping load_mode after two of five words
        start_burst(8'h40);
        push_word(16'hAAAA, 1'b0);
        push_word(16'hBBBB, 1'b0);
        load_mode = 1'b0;
        push_word(16'hCCCC, 1'b0);
        check("abort_count", 32'(load_count), 32'd2);
        check("abort_ready", 32'(load_ready), 32'd0);
        check("abort_idle", 32'(busy), 32'd0);
        cpu_read(16'h0040, 16'hAAAA, "abort_rd_40");
        cpu_read(16'h0041, 16'hBBBB, "abort_rd_41");
        cpu_read(16'h0042, 16'h0000, "abort_rd_42");

        // Host ownership blocks CPU reads and writes
        load_mode = 1'b1;
        wr          = WR_READ;
        address_bus = 16'h0012;
        #1;
        check("host_bus_float", 32'(data_bus), 32'(BUS_FLOAT));
        cycle();
        cpu_write(16'h0005, 16'h7777);
        load_mode = 1'b0;
        cpu_read(16'h0005, 16'h0000, "host_wr_ignored");

        // Saturating count over a 258-word wrapping burst
        start_burst(8'h80);
        for (int i = 0; i < 258; i++) begin
            push_word(16'(i), (i == 257) ? 1'b1 : 1'b0);
        end
        check("sat_count", 32'(load_count), 32'd256);
        load_mode = 1'b0;
        cpu_read(16'h0080, 16'h0100, "sat_rd_80");
        cpu_read(16'h0081, 16'h0101, "sat_rd_81");
        cpu_read(16'h0082, 16'h0002, "sat_rd_82");

        // Asynchronous reset in the middle of a burst
        start_burst(8'h10);
        push_word(16'h9999, 1'b0);
        push_word(16'h8888, 1'b0);
        load_valid = 1'b1;
        load_data  = 16'h7777;
        #2;
        reset = 1'b0;
        #1;
        check("midrst_ready", 32'(load_ready), 32'd0);
        check("midrst_busy", 32'(busy), 32'd1);
        check("midrst_count", 32'(load_count), 32'd0);
        @(negedge clk);
        load_mode  = 1'b0;
        load_valid = 1'b0;
        reset      = 1'b1;
        wait_clear("midrst_clear_cycles");
        cpu_read(16'h0010, 16'h0000, "midrst_rd_10");
        cpu_read(16'h0011, 16'h0000, "midrst_rd_11");
        cpu_read(16'h0012, 16'h0000, "midrst_rd_12");
        cpu_read(16'h0080, 16'h0000, "midrst_rd_80");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
